// File: rtl/wb_pkg.sv
// Shared types for the writeback stage: FSM state encoding and the buffered entry layout.
package wb_pkg;

    // Entry data field is sized for the widest supported XLEN; narrower builds zero-extend.
    localparam int WB_MAX_XLEN = 64;

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } wb_state_t;

    typedef struct packed {
        logic [4:0]             rd;
        logic [WB_MAX_XLEN-1:0] data;
        logic                   err;
    } wb_entry_t;

endpackage

// File: rtl/wb_skid_fifo.sv
// Two-entry FIFO decoupling result production from register-file acceptance.
module wb_skid_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [1:0]       count,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Head reads as zero when empty so stale entries never leak onto the outputs.
    assign rdata = (count_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
    assign count = count_q;
    assign empty = (count_q == 2'd0);

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: selects a pre-formatted result or waits for load data, then
// buffers {rd, data, err} in a 2-entry FIFO feeding the register file.
//
// state     | meaning
// IDLE      | accepting requests while the buffer has room
// LOAD_WAIT | load issued, waiting for mem_rvalid; no new requests
module writeback_stage
    import wb_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_SRC  = 4,
    parameter int LOAD_SRC = 3,
    parameter int SEL_W    = $clog2(NUM_SRC)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clk_enable,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic [4:0]              in_rd,
    input  logic [NUM_SRC*XLEN-1:0] in_src_data,
    input  logic                    mem_rvalid,
    input  logic [XLEN-1:0]         mem_rdata,
    input  logic                    mem_rerr,
    output logic                    wb_valid,
    input  logic                    wb_ready,
    output logic                    wb_we,
    output logic [4:0]              wb_rd,
    output logic [XLEN-1:0]         wb_data,
    output logic                    wb_err,
    output logic                    busy
);

    localparam int ENTRY_W = $bits(wb_entry_t);

    wb_state_t       state_q;
    wb_state_t       state_d;
    logic [4:0]      load_rd_q;
    logic [XLEN-1:0] sel_data;
    logic            sel_ok;
    logic            is_load;
    logic            accept;
    logic            push;
    logic            pop;
    wb_entry_t       push_entry;
    wb_entry_t       head;
    logic [1:0]      fifo_count;
    logic            fifo_empty;

    always_comb begin
        sel_data = '0;
        sel_ok   = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (in_sel == SEL_W'(i)) begin
                sel_data = in_src_data[i*XLEN +: XLEN];
                sel_ok   = 1'b1;
            end
        end
    end

    assign is_load  = (in_sel == SEL_W'(LOAD_SRC));
    assign in_ready = clk_enable && (state_q == IDLE) && (fifo_count < 2'd2);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        push       = 1'b0;
        push_entry = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_load) begin
                        state_d = LOAD_WAIT;
                    end else begin
                        push = 1'b1;
                        // Out-of-range selects retire as rd=0 so the write is suppressed.
                        push_entry.rd   = sel_ok ? in_rd : 5'd0;
                        push_entry.data = WB_MAX_XLEN'(sel_data);
                    end
                end
            end
            LOAD_WAIT: begin
                if (clk_enable && mem_rvalid) begin
                    push            = 1'b1;
                    push_entry.rd   = load_rd_q;
                    push_entry.data = WB_MAX_XLEN'(mem_rdata);
                    push_entry.err  = mem_rerr;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            load_rd_q <= 5'd0;
        end else begin
            state_q <= state_d;
            if (accept && is_load) begin
                load_rd_q <= in_rd;
            end
        end
    end

    wb_skid_fifo #(
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    generate
        if (XLEN < WB_MAX_XLEN) begin : g_pad
            logic unused_data_hi;
            assign unused_data_hi = ^head.data[WB_MAX_XLEN-1:XLEN];
        end
    endgenerate

    assign wb_valid = clk_enable && !fifo_empty;
    assign pop      = wb_valid && wb_ready;
    assign wb_rd    = head.rd;
    assign wb_data  = head.data[XLEN-1:0];
    assign wb_err   = head.err;
    assign wb_we    = wb_valid && (head.rd != 5'd0) && !head.err;
    assign busy     = (state_q == LOAD_WAIT) || !fifo_empty;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed scenarios plus randomized traffic checked against a queue-based reference model.
module tb_writeback_stage;

    localparam int XLEN     = 32;
    localparam int NUM_SRC  = 4;
    localparam int LOAD_SRC = 3;
    localparam int SEL_W    = 2;

    logic                    clk;
    logic                    rst_n;
    logic                    clk_enable;
    logic                    in_valid;
    logic                    in_ready;
    logic [SEL_W-1:0]        in_sel;
    logic [4:0]              in_rd;
    logic [NUM_SRC*XLEN-1:0] in_src_data;
    logic                    mem_rvalid;
    logic [XLEN-1:0]         mem_rdata;
    logic                    mem_rerr;
    logic                    wb_valid;
    logic                    wb_ready;
    logic                    wb_we;
    logic [4:0]              wb_rd;
    logic [XLEN-1:0]         wb_data;
    logic                    wb_err;
    logic                    busy;

    logic [XLEN-1:0] src [NUM_SRC];
    assign in_src_data = {src[3], src[2], src[1], src[0]};

    int vectors     = 0;
    int miscompares = 0;

    writeback_stage #(
        .XLEN     (XLEN),
        .NUM_SRC  (NUM_SRC),
        .LOAD_SRC (LOAD_SRC),
        .SEL_W    (SEL_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_enable  (clk_enable),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sel      (in_sel),
        .in_rd       (in_rd),
        .in_src_data (in_src_data),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .mem_rerr    (mem_rerr),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_we       (wb_we),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .wb_err      (wb_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        clk_enable = 1'b1;
        in_valid   = 1'b0;
        in_sel     = '0;
        in_rd      = '0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        mem_rerr   = 1'b0;
        wb_ready   = 1'b1;
        for (int i = 0; i < NUM_SRC; i++) src[i] = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #2;
        vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL reset_wb_valid: got %0b want 0", wb_valid); end
        vectors++; if ({wb_we, wb_rd, wb_data, wb_err} !== '0) begin miscompares++; $display("FAIL reset_wb_fields: got we=%0b rd=%0d data=%h err=%0b want all 0", wb_we, wb_rd, wb_data, wb_err); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b want 0", busy); end
        cyc();
        cyc();
        rst_n = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_alu();
        in_valid = 1'b1; in_sel = 2'd1; in_rd = 5'd5; src[1] = 32'h1234_5678; wb_ready = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL alu_in_ready: got %0b want 1", in_ready); end
        cyc();
        in_valid = 1'b0;
        #1;
        vectors++; if ({wb_valid, wb_we, wb_rd, wb_data} !== {1'b1, 1'b1, 5'd5, 32'h1234_5678}) begin miscompares++; $display("FAIL alu_out: got v=%0b we=%0b rd=%0d data=%h want v=1 we=1 rd=5 data=12345678", wb_valid, wb_we, wb_rd, wb_data); end
        cyc();
        #1;
        vectors++; if ({wb_valid, wb_rd, wb_data, wb_err} !== '0) begin miscompares++; $display("FAIL alu_drained: got v=%0b rd=%0d data=%h err=%0b want all 0", wb_valid, wb_rd, wb_data, wb_err); end
    endtask

    task automatic test_load();
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_0001;
        cyc();
        mem_rvalid = 1'b0;
        #1;
        vectors++; if ({wb_valid, busy} !== 2'b00) begin miscompares++; $display("FAIL idle_rvalid_ignored: got v=%0b busy=%0b want 0 0", wb_valid, busy); end
        in_valid = 1'b1; in_sel = 2'd3; in_rd = 5'd7;
        cyc();
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            vectors++; if ({in_ready, wb_valid, busy} !== 3'b001) begin miscompares++; $display("FAIL load_wait_%0d: got rdy=%0b v=%0b busy=%0b want 0 0 1", i, in_ready, wb_valid, busy); end
            cyc();
        end
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL load_wait_last: got rdy=%0b want 0", in_ready); end
        cyc();
        mem_rvalid = 1'b0;
        #1;
        vectors++; if ({wb_valid, wb_we, wb_rd, wb_data, wb_err} !== {1'b1, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0}) begin miscompares++; $display("FAIL load_out: got v=%0b we=%0b rd=%0d data=%h err=%0b want 1 1 7 deadbeef 0", wb_valid, wb_we, wb_rd, wb_data, wb_err); end
        cyc();
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [3];
        vals[0] = 32'hAAAA_0001; vals[1] = 32'hBBBB_0002; vals[2] = 32'hCCCC_0003;
        wb_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd1;
        for (int i = 0; i < 3; i++) begin
            in_rd = 5'(i + 1); src[1] = vals[i];
            #1;
            vectors++; if (in_ready !== (i < 2)) begin miscompares++; $display("FAIL b2b_ready_%0d: got %0b want %0b", i, in_ready, (i < 2)); end
            cyc();
        end
        in_valid = 1'b0; wb_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            vectors++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'(i + 1), vals[i]}) begin miscompares++; $display("FAIL b2b_drain_%0d: got v=%0b rd=%0d data=%h want 1 %0d %h", i, wb_valid, wb_rd, wb_data, i + 1, vals[i]); end
            cyc();
        end
        #1;
        vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_empty: got %0b want 0", wb_valid); end
    endtask

    task automatic test_rd0_err();
        in_valid = 1'b1; in_sel = 2'd0; in_rd = 5'd0; src[0] = 32'hFFFF_F000;
        cyc();
        in_valid = 1'b0;
        #1;
        vectors++; if ({wb_valid, wb_we, wb_data} !== {1'b1, 1'b0, 32'hFFFF_F000}) begin miscompares++; $display("FAIL rd0_out: got v=%0b we=%0b data=%h want 1 0 fffff000", wb_valid, wb_we, wb_data); end
        cyc();
        in_valid = 1'b1; in_sel = 2'd3; in_rd = 5'd9;
        cyc();
        in_valid = 1'b0; mem_rvalid = 1'b1; mem_rerr = 1'b1; mem_rdata = 32'h0000_0055;
        cyc();
        mem_rvalid = 1'b0; mem_rerr = 1'b0;
        #1;
        vectors++; if ({wb_valid, wb_err, wb_we, wb_rd} !== {1'b1, 1'b1, 1'b0, 5'd9}) begin miscompares++; $display("FAIL load_err_out: got v=%0b err=%0b we=%0b rd=%0d want 1 1 0 9", wb_valid, wb_err, wb_we, wb_rd); end
        cyc();
        #1;
        vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL err_handshake: got v=%0b want 0", wb_valid); end
    endtask

    task automatic test_reset_in_load();
        in_valid = 1'b1; in_sel = 2'd3; in_rd = 5'd4;
        cyc();
        in_valid = 1'b0;
        #1;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rst_load_busy_pre: got %0b want 1", busy); end
        rst_n = 1'b0;
        #1;
        vectors++; if ({busy, wb_valid} !== 2'b00) begin miscompares++; $display("FAIL rst_load_async: got busy=%0b v=%0b want 0 0", busy, wb_valid); end
        cyc();
        rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        cyc();
        mem_rvalid = 1'b0;
        #1;
        vectors++; if ({wb_valid, busy, in_ready} !== 3'b001) begin miscompares++; $display("FAIL rst_load_after: got v=%0b busy=%0b rdy=%0b want 0 0 1", wb_valid, busy, in_ready); end
    endtask

    task automatic test_clk_enable();
        wb_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd2; in_rd = 5'd11; src[2] = 32'hCAFE_0002;
        cyc();
        in_valid = 1'b0; clk_enable = 1'b0; wb_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++; if ({wb_valid, in_ready, busy} !== 3'b001) begin miscompares++; $display("FAIL gated_%0d: got v=%0b rdy=%0b busy=%0b want 0 0 1", i, wb_valid, in_ready, busy); end
            cyc();
        end
        clk_enable = 1'b1;
        #1;
        vectors++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd11, 32'hCAFE_0002}) begin miscompares++; $display("FAIL gated_deliver: got v=%0b rd=%0d data=%h want 1 11 cafe0002", wb_valid, wb_rd, wb_data); end
        cyc();
        #1;
        vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL gated_once: got v=%0b want 0", wb_valid); end
    endtask

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        err;
    } ent_t;

    task automatic test_random();
        ent_t        q[$];
        ent_t        h;
        bit          pend;
        logic [4:0]  prd;
        logic        e_ready, e_valid, e_we, e_busy;
        logic [44:0] got, want;
        pend = 0; prd = '0;
        idle_inputs();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            clk_enable = ($urandom_range(0, 9) != 0);
            in_valid   = 1'($urandom);
            in_sel     = 2'($urandom_range(0, 3));
            in_rd      = 5'($urandom);
            for (int i = 0; i < NUM_SRC; i++) src[i] = $urandom;
            wb_ready   = ($urandom_range(0, 3) != 0);
            mem_rvalid = ($urandom_range(0, 3) == 0);
            mem_rdata  = $urandom;
            mem_rerr   = ($urandom_range(0, 7) == 0);
            #1;
            h = '{5'd0, 32'd0, 1'b0};
            if (q.size() > 0) h = q[0];
            e_ready = clk_enable && !pend && (q.size() < 2);
            e_valid = clk_enable && (q.size() > 0);
            e_we    = e_valid && (h.rd != 0) && !h.err;
            e_busy  = pend || (q.size() > 0);
            want = {e_ready, e_valid, e_we, h.rd, h.data, h.err, e_busy};
            got  = {in_ready, wb_valid, wb_we, wb_rd, wb_data, wb_err, busy};
            vectors++; if (got !== want) begin miscompares++; $display("FAIL random_%0d: got %h want %h", n, got, want); end
            if (clk_enable) begin
                if (e_valid && wb_ready) q.delete(0);
                if (in_valid && e_ready) begin
                    if (in_sel == 2'(LOAD_SRC)) begin
                        pend = 1; prd = in_rd;
                    end else begin
                        q.push_back('{in_rd, src[in_sel], 1'b0});
                    end
                end else if (pend && mem_rvalid) begin
                    q.push_back('{prd, mem_rdata, mem_rerr});
                    pend = 0;
                end
            end
            cyc();
        end
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_alu();
        test_load();
        test_back_to_back();
        test_rd0_err();
        test_reset_in_load();
        test_clk_enable();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the data width of every source, load and writeback datum.
REQ-002 Parameter NUM_SRC, default 4, SHALL set the number of pre-formatted result sources (upper-imm, ALU, return address, load).
REQ-003 Parameter LOAD_SRC, default 3, SHALL give the select index that denotes a memory load; it SHALL be less than NUM_SRC.
REQ-004 Parameter SEL_W, default $clog2(NUM_SRC), SHALL set the select width.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 clk_enable  input  1  pipeline advance enable.
REQ-008 in_valid  input  1  upstream result request valid.
REQ-009 in_ready  output  1  stage can accept a request.
REQ-010 in_sel  input  SEL_W  source select.
REQ-011 in_rd  input  5  destination register.
REQ-012 in_src_data  input  NUM_SRC*XLEN  flattened sources; source i at bits [i*XLEN +: XLEN].
REQ-013 mem_rvalid  input  1  load data returning.
REQ-014 mem_rdata  input  XLEN  load data.
REQ-015 mem_rerr  input  1  load access fault.
REQ-016 wb_valid  output  1  writeback entry valid.
REQ-017 wb_ready  input  1  register file accepts entry.
REQ-018 wb_we  output  1  register write enable (0 when rd==0 or error).
REQ-019 wb_rd  output  5  destination register.
REQ-020 wb_data  output  XLEN  writeback data.
REQ-021 wb_err  output  1  entry carries a load fault.
REQ-022 busy  output  1  load outstanding or buffer non-empty.

Function
REQ-023 A transfer SHALL occur only on an edge where clk_enable=1; in_ready and wb_valid SHALL be forced to 0 while clk_enable=0, and no state SHALL change.
REQ-024 FSM states: IDLE and LOAD_WAIT; in_ready SHALL equal clk_enable AND state==IDLE AND buffer count<2, with no combinational path from wb_ready.
REQ-025 Accepted request with in_sel!=LOAD_SRC SHALL push {in_rd, selected source, err=0} to the buffer on the same edge; wb_valid SHALL be visible the next cycle (latency 1).
REQ-026 Accepted request with in_sel==LOAD_SRC SHALL capture in_rd and move to LOAD_WAIT without pushing.
REQ-027 In LOAD_WAIT, mem_rvalid=1 SHALL push {captured rd, mem_rdata, mem_rerr} and return to IDLE; wb_valid SHALL be visible the next cycle.
REQ-028 mem_rvalid while in IDLE SHALL be ignored.
REQ-029 in_sel>=NUM_SRC SHALL push data 0 with wb_we=0.
REQ-030 The buffer SHALL be a 2-entry FIFO; the head drives wb_*; the head SHALL pop when wb_valid AND wb_ready.
REQ-031 Simultaneous push and pop SHALL keep the count unchanged and preserve order; push is never attempted when full (REQ-024).
REQ-032 Wrap-around of the FIFO read/write pointers SHALL NOT reorder or lose entries.
REQ-033 wb_we SHALL be 0 for rd==0 or wb_err=1; such entries SHALL still handshake.
REQ-034 When the buffer is empty, wb_rd, wb_data and wb_err SHALL read 0.

Reset
REQ-035 rst_n=0 SHALL immediately force state IDLE, buffer empty, wb_valid 0, wb_we 0, wb_rd 0, wb_data 0, wb_err 0 and busy 0.
REQ-036 Reset during LOAD_WAIT SHALL discard the pending load; a later mem_rvalid SHALL be ignored.
REQ-037 After reset release with clk_enable=1, in_ready SHALL be 1.

Structure
REQ-038 Package wb_pkg SHALL hold the FSM state enum (IDLE, LOAD_WAIT) and the buffer entry struct {rd, data, err}.
REQ-039 The FIFO SHALL be a sub-module wb_skid_fifo, parametrised by entry width, depth 2.

Verification
REQ-040 ALU (sel=1, rd=5, data 0x1234_5678), wb_ready=1 -> next cycle wb_valid=1, wb_rd=5, wb_data=0x1234_5678, wb_we=1.
REQ-041 Load (sel=3, rd=7); mem_rvalid 3 cycles later with 0xDEAD_BEEF -> in_ready=0 throughout the wait; wb_data=0xDEAD_BEEF the cycle after mem_rvalid.
REQ-042 wb_ready=0, three back-to-back ALU requests -> two accepted, in_ready=0 on the third; wb_ready=1 drains them in order.
REQ-043 rd=0 with sel=0 data 0xFFFF_F000 -> wb_valid=1, wb_we=0; load with mem_rerr=1 -> wb_err=1, wb_we=0.
REQ-044 rst_n pulsed low in LOAD_WAIT, then mem_rvalid -> no wb_valid, busy=0, in_ready=1.
REQ-045 clk_enable=0 for 4 cycles with one entry buffered -> wb_valid=0, no pop; re-enable -> entry delivered once.
